// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// Grants are locked for bursts of up to MAX_BURST beats; the write port is registered.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 128,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_alm_full,
  input  logic                          fifo_full,
  output logic                          fifo_wren,
  output logic [DATA_WIDTH-1:0]         fifo_wrdata,
  output logic [2:0]                    grant_id,
  output logic                          busy
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  state_t                state_reg;
  logic [2:0]            last_gnt_reg;
  logic [CNT_W-1:0]      beat_cnt_reg;
  logic [CNT_W-1:0]      beat_cnt_next;
  logic [NUM_REQ-1:0]    gnt_onehot;
  logic                  gnt_valid;
  logic                  gnt_last;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic [DATA_WIDTH-1:0] masked_data [NUM_REQ];
  logic [2:0]            pick;
  logic                  pick_found;
  int                    cand;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_sel
      assign gnt_onehot[gi]  = (grant_id == 3'(gi));
      assign masked_data[gi] = gnt_onehot[gi] ? req_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  endgenerate

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_data = gnt_data | masked_data[i];
    end
  end

  assign req_ready     = (state_reg == BURST) ? gnt_onehot : '0;
  assign gnt_valid     = |(req_valid & gnt_onehot);
  assign gnt_last      = |(req_last & gnt_onehot);
  assign busy          = (state_reg != IDLE);
  assign beat_cnt_next = beat_cnt_reg + CNT_W'(1);

  // Walk from the farthest candidate back toward last_gnt+1 so the nearest valid one wins.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    cand       = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = int'(last_gnt_reg) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (req_valid[cand]) begin
        pick       = 3'(cand);
        pick_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_reg    <= IDLE;
      fifo_wren    <= 1'b0;
      fifo_wrdata  <= '0;
      grant_id     <= '0;
      last_gnt_reg <= 3'(NUM_REQ - 1);
      beat_cnt_reg <= '0;
    end else begin
      fifo_wren <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pick_found && !fifo_alm_full && !fifo_full) begin
            grant_id     <= pick;
            last_gnt_reg <= pick;
            beat_cnt_reg <= '0;
            state_reg    <= BURST;
          end
        end
        BURST: begin
          if (gnt_valid) begin
            fifo_wren    <= 1'b1;
            fifo_wrdata  <= gnt_data;
            beat_cnt_reg <= beat_cnt_next;
            if (gnt_last || (beat_cnt_next == CNT_W'(MAX_BURST))) begin
              state_reg <= GAP;
            end
          end else begin
            state_reg <= GAP;
          end
        end
        // One idle cycle lets the FIFO count settle before the next almost-full check.
        GAP:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized bench for fifo_wr_arbiter with a queue-based FIFO model
// (DEPTH=10, UPP_TH=4) and a transaction scoreboard of accepted beats.
module tb_fifo_wr_arbiter;
  localparam int NR     = 4;
  localparam int DW     = 128;
  localparam int MB     = 4;
  localparam int DEPTH  = 10;
  localparam int UPP_TH = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic             fifo_alm_full;
  logic             fifo_full;
  logic             fifo_wren;
  logic [DW-1:0]    fifo_wrdata;
  logic [2:0]       grant_id;
  logic             busy;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_alm_full(fifo_alm_full),
    .fifo_full(fifo_full), .fifo_wren(fifo_wren), .fifo_wrdata(fifo_wrdata),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            passed = 0;
  int            fails = 0;
  int            wr_count = 0;
  int            cycle = 0;
  bit            drain;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_flags();
    fifo_alm_full = (fifo_q.size() >= DEPTH - UPP_TH);
    fifo_full     = (fifo_q.size() >= DEPTH);
  endtask

  task automatic put(int p, logic [DW-1:0] d);
    req_data[p*DW +: DW] = d;
  endtask

  // One clock: record accepted beats, apply the FIFO write/read of this edge, check the write.
  task automatic tick();
    logic          pw;
    logic [DW-1:0] pd;
    logic [DW-1:0] e;
    logic [NR-1:0] acc;
    pw  = fifo_wren;
    pd  = fifo_wrdata;
    acc = req_valid & req_ready;
    if (rstn === 1'b0) begin
      for (int i = 0; i < NR; i++) begin
        if (acc[i] === 1'b1) exp_q.push_back(req_data[i*DW +: DW]);
      end
    end
    @(posedge clk);
    #1;
    cycle++;
    if (drain && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (pw === 1'b1) begin
      wr_count++;
      $display("[%0d] fifo write data=%h", cycle, pd);
      chk("wr_room", fifo_q.size() < DEPTH, 1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : ~pd;
      chk("wr_data", pd, e);
      fifo_q.push_back(pd);
    end
    fifo_flags();
  endtask

  function automatic int rr_pick(logic [NR-1:0] v, int last);
    int r;
    bit f;
    r = -1;
    f = 1'b0;
    for (int k = 1; k <= NR; k++) begin
      if (!f && v[(last + k) % NR]) begin
        r = (last + k) % NR;
        f = 1'b1;
      end
    end
    return r;
  endfunction

  logic [NR-1:0] pr, pv, pl, acc, exp_r;
  logic          pre_room, pre_busy;
  logic [DW-1:0] cur_data [NR];
  logic          cur_last [NR];
  int            k, run, nruns, run0, run1, w0, last_acc, exp_g, ngr, rr_last, bn, g, pk;
  int            seq [NR];

  initial begin
    rstn = 1'b1; req_valid = '0; req_last = '0; req_data = '0; drain = 1'b1;
    fifo_flags();

    // Reset with every producer requesting
    req_valid = '1;
    for (int p = 0; p < NR; p++) put(p, DW'(32'h1000 + p));
    tick(); tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_wren", fifo_wren, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_busy", busy, 0);
    rstn = 1'b0;
    tick();
    chk("rel_gid", grant_id, 0);
    chk("rel_ready", req_ready, 4'b0001);
    chk("rel_wren0", fifo_wren, 0);
    tick();
    chk("rel_wren1", fifo_wren, 1);
    req_valid = '0;
    repeat (4) tick();

    // Three-beat burst from producer 2
    req_valid = 4'b0100; put(2, DW'(32'hA));
    tick();
    chk("b3_gid", grant_id, 2);
    chk("b3_ready", req_ready, 4'b0100);
    chk("b3_wren0", fifo_wren, 0);
    tick();
    chk("b3_dA", fifo_wrdata, 32'hA);
    chk("b3_wenA", fifo_wren, 1);
    put(2, DW'(32'hB));
    tick();
    chk("b3_dB", fifo_wrdata, 32'hB);
    put(2, DW'(32'hC)); req_last = 4'b0100;
    tick();
    chk("b3_dC", fifo_wrdata, 32'hC);
    chk("b3_gap_ready", req_ready, 0);
    chk("b3_gap_busy", busy, 1);
    req_valid = '0; req_last = '0;
    tick();
    chk("b3_idle_wren", fifo_wren, 0);
    chk("b3_idle_busy", busy, 0);

    // MAX_BURST cut: six beats from producer 1 without last
    k = 0; run = 0; nruns = 0; run0 = 0; run1 = 0;
    for (int c = 0; c < 30; c++) begin
      req_valid = (k < 6) ? 4'b0010 : 4'b0000;
      put(1, DW'(32'h100 + k));
      pr  = req_ready;
      acc = req_valid & req_ready;
      tick();
      if (acc[1]) begin k++; run++; end
      if (!pr[1] && req_ready[1]) chk("cut_gid", grant_id, 1);
      if (pr[1] && !req_ready[1]) begin
        if (nruns == 0) run0 = run; else run1 = run;
        nruns++;
        run = 0;
      end
    end
    chk("cut_runs", nruns, 2);
    chk("cut_run0", run0, MB);
    chk("cut_run1", run1, 2);

    // Round-robin with continuous single-beat bursts from everyone, fresh pointer
    rstn = 1'b1; req_valid = '0; tick(); rstn = 1'b0;
    last_acc = -1; exp_g = 0; ngr = 0;
    for (int p = 0; p < NR; p++) seq[p] = 0;
    for (int c = 0; c < 40; c++) begin
      for (int p = 0; p < NR; p++) put(p, DW'(p * 256 + seq[p]));
      req_valid = '1; req_last = '1;
      pr  = req_ready;
      acc = req_valid & req_ready;
      tick();
      if (acc != 0) begin
        if (last_acc >= 0) chk("rr_spacing", c - last_acc, 3);
        last_acc = c;
        for (int p = 0; p < NR; p++) if (acc[p]) seq[p]++;
      end
      if (pr == 0 && req_ready != 0) begin
        chk("rr_order", grant_id, exp_g);
        exp_g = (exp_g + 1) % NR;
        ngr++;
      end
    end
    req_valid = '0; req_last = '0;
    repeat (3) tick();
    chk("rr_count", ngr >= 12, 1);

    // Almost-full throttle: count 6 blocks, count 5 admits one 4-beat burst up to 9
    drain = 1'b0;
    fifo_q.delete();
    for (int i = 0; i < 6; i++) fifo_q.push_back(DW'(32'hF000 + i));
    fifo_flags();
    k = 0;
    for (int c = 0; c < 5; c++) begin
      req_valid = 4'b0001; put(0, DW'(32'h500 + k));
      tick();
      chk("af_hold", req_ready, 0);
    end
    void'(fifo_q.pop_front());
    fifo_flags();
    for (int c = 0; c < 14; c++) begin
      req_valid = 4'b0001; put(0, DW'(32'h500 + k));
      acc = req_valid & req_ready;
      tick();
      if (acc[0]) k++;
    end
    chk("af_beats", k, MB);
    chk("af_count", fifo_q.size(), 9);
    req_valid = '0;
    for (int i = 0; i < 9; i++) begin
      chk("af_order", fifo_q.size() > 0 ? fifo_q.pop_front() : '1,
          (i < 5) ? DW'(32'hF001 + i) : DW'(32'h500 + i - 5));
    end
    drain = 1'b1;
    fifo_flags();
    tick();

    // Bubble after one beat from producer 3
    req_valid = 4'b1000; put(3, DW'(32'h300));
    tick();
    chk("bub_gid", grant_id, 3);
    w0 = wr_count;
    tick();
    chk("bub_wren", fifo_wren, 1);
    req_valid = '0;
    tick();
    chk("bub_ready", req_ready, 0);
    chk("bub_wren_off", fifo_wren, 0);
    tick(); tick();
    chk("bub_writes", wr_count - w0, 1);

    // Reset during the second beat of a burst from producer 2
    req_valid = 4'b0100; put(2, DW'(32'h200));
    tick();
    chk("mr_gid2", grant_id, 2);
    tick();
    put(2, DW'(32'h201));
    rstn = 1'b1;
    w0 = wr_count;
    tick();
    chk("mr_wren", fifo_wren, 0);
    chk("mr_ready", req_ready, 0);
    rstn = 1'b0; req_valid = '1;
    tick();
    chk("mr_ptr", grant_id, 0);
    chk("mr_writes", wr_count - w0, 1);
    req_valid = '0;
    repeat (3) tick();

    // Randomized traffic against rule-level expectations
    rstn = 1'b1; tick(); rstn = 1'b0;
    rr_last = NR - 1; bn = 0;
    for (int p = 0; p < NR; p++) begin
      cur_data[p] = {$urandom, $urandom, $urandom, $urandom};
      cur_last[p] = ($urandom_range(0, 3) == 0);
    end
    for (int c = 0; c < 2000; c++) begin
      for (int p = 0; p < NR; p++) begin
        req_valid[p] = ($urandom_range(0, 9) < 7);
        req_last[p]  = cur_last[p];
        put(p, cur_data[p]);
      end
      drain    = 1'($urandom_range(0, 1));
      pr       = req_ready;
      pv       = req_valid;
      pl       = req_last;
      pre_room = !fifo_alm_full && !fifo_full;
      pre_busy = busy;
      tick();
      chk("rnd_onehot", $countones(req_ready) <= 1, 1);
      if (pr == 0) begin
        if (!pre_busy) begin
          pk    = rr_pick(pv, rr_last);
          exp_r = (pv != 0 && pre_room) ? (NR'(1) << pk) : '0;
          chk("rnd_grant", req_ready, exp_r);
          if (exp_r != 0) begin
            chk("rnd_gid", grant_id, pk);
            rr_last = pk;
            bn = 0;
          end
        end else begin
          chk("rnd_gap", busy, 0);
        end
      end else begin
        g = 0;
        for (int p = 0; p < NR; p++) if (pr[p]) g = p;
        if (pv[g]) begin
          bn++;
          cur_data[g] = {$urandom, $urandom, $urandom, $urandom};
          cur_last[g] = ($urandom_range(0, 3) == 0);
        end
        exp_r = (!pv[g] || pl[g] || bn == MB) ? '0 : pr;
        chk("rnd_burst", req_ready, exp_r);
      end
    end
    req_valid = '0; req_last = '0; drain = 1'b1;
    repeat (6) tick();
    chk("rnd_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares the single write port of sync_fifo among NUM_REQ producers.
- Each producer uses a valid/ready burst interface. The arbiter grants one producer at a time, locks the grant for a burst of up to MAX_BURST beats, and drives the FIFO write port through one register stage.
- Throttles on the FIFO almost-full flag so the FIFO never sees a write it would silently drop.

Parameters:
- NUM_REQ, 4, number of producers (2..8).
- DATA_WIDTH, 128, beat width; must equal the FIFO data width.
- MAX_BURST, 4, maximum beats per grant; must be ≤ FIFO UPP_TH.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rstn  input  1  reset, synchronous and active-high (asserted = 1 resets).
- req_valid  input  NUM_REQ  per-producer beat valid.
- req_data  input  NUM_REQ*DATA_WIDTH  per-producer beat data; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NUM_REQ  per-producer final beat of burst.
- req_ready  output  NUM_REQ  per-producer beat accepted this cycle when valid & ready.
- fifo_alm_full  input  1  from FIFO o_alm_full.
- fifo_full  input  1  from FIFO o_full.
- fifo_wren  output  1  to FIFO i_wren.
- fifo_wrdata  output  DATA_WIDTH  to FIFO i_wrdata.
- grant_id  output  3  index of the current or most recent grantee.
- busy  output  1  high in BURST and GAP states.

Behaviour:
- Reset (rstn=1 at a rising edge):
  - state=IDLE; fifo_wren=0; fifo_wrdata=0; req_ready=0; grant_id=0; busy=0; beat counter=0.
  - Round-robin pointer last_gnt=NUM_REQ-1, so producer 0 wins first.
  - Reset mid-burst abandons the burst; any beat that was registered but not yet written is discarded (fifo_wren=0 the cycle after reset).
- IDLE:
  - If any req_valid=1 and fifo_alm_full=0 and fifo_full=0, pick the first requester with valid high, searching last_gnt+1, last_gnt+2, ... modulo NUM_REQ.
  - Set grant_id to that requester, last_gnt to it, clear the beat counter, and go to BURST.
  - Otherwise stay in IDLE.
  - The grant decision is combinational on inputs and registered into state; req_ready is 0 in IDLE.
- BURST:
  - req_ready[grant_id] = 1, combinational from registered state; all other ready bits are 0.
  - Transfer occurs when req_valid[grant_id]=1.
  - On each transfer: fifo_wren<=1, fifo_wrdata<=that producer's beat, counter+1.
  - fifo_wren<=0 on any cycle without a transfer.
  - Go to GAP on any of:
    - a transfer with req_last=1;
    - a transfer that makes counter==MAX_BURST;
    - a cycle where req_valid[grant_id]=0 (bubble).
  - req_last is ignored while the burst continues; it only ends the burst.
- GAP:
  - Exactly one cycle; req_ready all 0.
  - fifo_wren carries the final registered beat if there was one, otherwise 0.
  - Next state is IDLE.
  - The gap guarantees the FIFO count reflects all issued writes before the next almost-full check.
- Overflow guarantee: a burst starts only when count < DEPTH-UPP_TH, and MAX_BURST ≤ UPP_TH. Therefore every issued write hits count < DEPTH. fifo_full is not expected during a burst; it is only a backstop for the start decision.
- Latency: the beat accepted at edge N appears on fifo_wren/fifo_wrdata after edge N and is written to the FIFO at edge N+1.
- Fairness: after a grant to i, requester i has lowest priority at the next arbitration. Under continuous requests from all producers, each is granted once per NUM_REQ arbitrations.
- Simultaneous events: a new requester's valid rising during another's BURST is not serviced until the next IDLE. fifo_alm_full rising mid-burst does not stop the burst.
- Width: the beat counter is clog2(MAX_BURST+1) bits, and the pointer and grant_id wrap modulo NUM_REQ.

Test Plan:
- Reset then idle: rstn=1 for 2 cycles with all req_valid=1 -> req_ready=0, fifo_wren=0, grant_id=0. After rstn=0, first grant goes to producer 0 and fifo_wren first rises 2 edges after release.
- Single producer, 3-beat burst: req 2 sends 0xA,0xB,0xC with last on 0xC -> ready[2] high 3 cycles, fifo_wrdata=A,B,C on consecutive cycles, then a 1-cycle GAP, then IDLE.
- MAX_BURST cut: producer 1 holds valid with no last for 6 beats -> exactly 4 beats written, then GAP/IDLE, re-grant to 1 (if sole requester) for the remaining 2 beats.
- Round-robin: all 4 producers each send continuous 1-beat bursts -> grant_id sequence 0,1,2,3,0,1..., with every 3rd cycle a transfer (ARB-BURST-GAP).
- Almost-full throttle: with the FIFO at DEPTH=10, UPP_TH=4 and count=6 (alm_full=1), assert req_valid[0] -> no grant until a FIFO read brings count to 5. From count=5, a 4-beat burst fills the FIFO to exactly 9, no beat is lost, and FIFO read order matches write order.
- Bubble and mid-burst reset: producer 3 drops valid after 1 beat -> burst ends after 1 beat. Separately, assert rstn during the 2nd beat of a burst -> no further fifo_wren, and the pointer returns to producer 0 priority.
